// File: rtl/simple_risc_core.sv
// simple_risc_core: 16-bit multicycle core. Instruction register, field decode,
// controller FSM and a datapath with an 8x16 register file, A/B/C registers,
// shifter, ALU and N/V/Z status register.
module simple_risc_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        N,
    output logic        V,
    output logic        Z,
    output logic        w
);

    typedef enum logic [3:0] {
        S_WAIT, S_DECODE, S_WIMM, S_GETA, S_GETB, S_MOVSH, S_ALU, S_CMP, S_WREG
    } state_t;

    typedef enum logic [1:0] {NSEL_RN, NSEL_RD, NSEL_RM} nsel_t;

    state_t      state_reg, state_next;
    logic        w_reg;
    logic [15:0] ir_reg, a_reg, b_reg, c_reg;
    logic        n_reg, v_reg, z_reg;
    logic [15:0] rf_reg [0:7];

    // Instruction fields
    logic [2:0]  opcode, rn, rd, rm;
    logic [1:0]  op, sh;
    logic [15:0] sximm8, sximm5;

    assign opcode = ir_reg[15:13];
    assign op     = ir_reg[12:11];
    assign rn     = ir_reg[10:8];
    assign rd     = ir_reg[7:5];
    assign sh     = ir_reg[4:3];
    assign rm     = ir_reg[2:0];
    assign sximm8 = {{8{ir_reg[7]}}, ir_reg[7:0]};
    assign sximm5 = {{11{ir_reg[4]}}, ir_reg[4:0]};

    // Datapath control and register-number selection
    nsel_t       nsel;
    logic [2:0]  regnum;
    logic        write_en, asel, bsel;
    logic [15:0] write_data, read_data;
    logic [7:0]  rf_we;

    // Pick which IR field addresses the register file in the current state
    always_comb begin
        nsel = NSEL_RM;
        case (state_reg)
            S_WIMM, S_GETA: nsel = NSEL_RN;
            S_WREG:         nsel = NSEL_RD;
            default:        nsel = NSEL_RM;
        endcase
        case (nsel)
            NSEL_RN: regnum = rn;
            NSEL_RD: regnum = rd;
            default: regnum = rm;
        endcase
    end

    assign write_en   = (state_reg == S_WIMM) || (state_reg == S_WREG);
    // vsel: immediate writeback only in WIMM, otherwise the C register
    assign write_data = (state_reg == S_WIMM) ? sximm8 : c_reg;
    assign read_data  = rf_reg[regnum];
    assign asel       = (state_reg == S_MOVSH);
    // The immediate ALU operand is decoded but no instruction selects it
    assign bsel       = 1'b0;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rf_we
            assign rf_we[gi] = write_en && (regnum == 3'(gi));
        end
    endgenerate

    // Shifter and ALU
    logic [15:0] b_shift, ain, bin, alu_res;
    logic        alu_ovf;

    // Shift B, select operands and compute the ALU result
    always_comb begin
        case (sh)
            2'b01:   b_shift = {b_reg[14:0], 1'b0};
            2'b10:   b_shift = {1'b0, b_reg[15:1]};
            2'b11:   b_shift = {b_reg[15], b_reg[15:1]};
            default: b_shift = b_reg;
        endcase
        ain = asel ? 16'h0000 : a_reg;
        bin = bsel ? sximm5 : b_shift;
        case (op)
            2'b00:   alu_res = ain + bin;
            2'b01:   alu_res = ain - bin;
            2'b10:   alu_res = ain & bin;
            default: alu_res = ~bin;
        endcase
        // Signed overflow of a subtraction: operand signs differ, result sign flips from Ain
        alu_ovf = (ain[15] != bin[15]) && (alu_res[15] != ain[15]);
    end

    // Next-state logic of the controller
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_WAIT:   state_next = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if (opcode == 3'b110 && op == 2'b10)      state_next = S_WIMM;
                else if (opcode == 3'b110 && op == 2'b00) state_next = S_GETB;
                else if (opcode == 3'b101 && op == 2'b11) state_next = S_GETB;
                else if (opcode == 3'b101)                state_next = S_GETA;
                else                                      state_next = S_WAIT;
            end
            S_GETA:   state_next = S_GETB;
            S_GETB: begin
                // IR may have been reloaded mid-instruction; unknown encodings bail out
                if (opcode == 3'b110 && op == 2'b00) state_next = S_MOVSH;
                else if (opcode == 3'b101)           state_next = (op == 2'b01) ? S_CMP : S_ALU;
                else                                 state_next = S_WAIT;
            end
            S_MOVSH, S_ALU: state_next = S_WREG;
            default:  state_next = S_WAIT;
        endcase
    end

    // Controller state and registered ready flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_WAIT;
            w_reg     <= 1'b1;
        end else begin
            state_reg <= state_next;
            w_reg     <= (state_next == S_WAIT);
        end
    end

    // Instruction, operand, result and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_reg <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            c_reg  <= '0;
            n_reg  <= 1'b0;
            v_reg  <= 1'b0;
            z_reg  <= 1'b0;
        end else begin
            if (load)                                          ir_reg <= in;
            if (state_reg == S_GETA)                           a_reg  <= read_data;
            if (state_reg == S_GETB)                           b_reg  <= read_data;
            if (state_reg == S_MOVSH || state_reg == S_ALU)    c_reg  <= alu_res;
            if (state_reg == S_CMP) begin
                n_reg <= alu_res[15];
                v_reg <= alu_ovf;
                z_reg <= (alu_res == 16'h0000);
            end
        end
    end

    // Register file: cleared by reset, one write port
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (reset)         rf_reg[i] <= '0;
            else if (rf_we[i]) rf_reg[i] <= write_data;
        end
    end

    assign out = c_reg;
    assign N   = n_reg;
    assign V   = v_reg;
    assign Z   = z_reg;
    assign w   = w_reg;

endmodule

// File: tb/tb_simple_risc_core.sv
// Testbench for simple_risc_core: runs an instruction sequence, pushing the
// expected latency/out/flags per instruction to a scoreboard queue and
// comparing when the core returns to WAIT.
module tb_simple_risc_core;

    logic        clk, reset, s, load;
    logic [15:0] in, out;
    logic        N, V, Z, w;

    int pass_cnt  = 0;
    int check_cnt = 0;

    typedef struct {
        logic [15:0] instr;
        int          lat;
        logic [15:0] out;
        logic        n, v, z;
    } exp_t;

    exp_t sb_q[$];

    simple_risc_core dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .out(out), .N(N), .V(V), .Z(Z), .w(w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Load an instruction, start it and compare against the scoreboard on completion
    task automatic exec(input logic [15:0] instr, input int lat, input logic [15:0] eo,
                        input logic en, input logic ev, input logic ez);
        exp_t e;
        int   cyc;
        e.instr = instr; e.lat = lat; e.out = eo; e.n = en; e.v = ev; e.z = ez;
        sb_q.push_back(e);
        @(posedge clk); #1;
        load = 1'b1; in = instr;
        @(posedge clk); #1;
        load = 1'b0; s = 1'b1;
        @(posedge clk); #1;
        s = 1'b0;
        cyc = 0;
        while (w !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb_q.pop_front();
        check($sformatf("lat_%h", e.instr), cyc, e.lat);
        check($sformatf("out_%h", e.instr), out, e.out);
        check($sformatf("N_%h", e.instr), N, e.n);
        check($sformatf("V_%h", e.instr), V, e.v);
        check($sformatf("Z_%h", e.instr), Z, e.z);
        $display("instr %h lat %0d out %h NVZ %b%b%b", e.instr, cyc, out, N, V, Z);
    endtask

    initial begin
        reset = 1'b1; s = 1'b0; load = 1'b0; in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_w", w, 1'b1);
        check("rst_out", out, 16'h0000);
        check("rst_nvz", {N, V, Z}, 3'b000);
        $display("reset out %h w %b NVZ %b%b%b", out, w, N, V, Z);

        exec(16'hD007, 2, 16'h0000, 0, 0, 0);   // MOV R0,#7
        exec(16'hD102, 2, 16'h0000, 0, 0, 0);   // MOV R1,#2
        exec(16'hA148, 5, 16'h0010, 0, 0, 0);   // ADD R2,R1,R0,LSL#1
        exec(16'hC0E2, 4, 16'h0010, 0, 0, 0);   // MOV R7,R2
        exec(16'hA801, 4, 16'h0010, 0, 0, 0);   // CMP R0,R1
        exec(16'hA908, 4, 16'h0010, 1, 0, 0);   // CMP R1,R0,LSL#1
        exec(16'hA800, 4, 16'h0010, 0, 0, 1);   // CMP R0,R0
        exec(16'hB860, 4, 16'hFFF8, 0, 0, 1);   // MVN R3,R0
        exec(16'hD4FF, 2, 16'hFFF8, 0, 0, 1);   // MOV R4,#-1
        exec(16'hC5B4, 4, 16'h7FFF, 0, 0, 1);   // MOV R5,R4,LSR#1
        exec(16'hC5BC, 4, 16'hFFFF, 0, 0, 1);   // MOV R5,R4,ASR#1
        exec(16'hB0E1, 5, 16'h0002, 0, 0, 1);   // AND R7,R0,R1
        exec(16'hC0E3, 4, 16'hFFF8, 0, 0, 1);   // MOV R7,R3
        exec(16'hD601, 2, 16'hFFF8, 0, 0, 1);   // MOV R6,#1
        for (int i = 1; i < 16; i++) begin
            logic [15:0] sv;
            sv = 16'h0001 << i;
            exec(16'hC6CE, 4, sv, 0, 0, 1);     // MOV R6,R6,LSL#1
        end
        exec(16'hAE01, 4, 16'h8000, 0, 1, 0);   // CMP R6,R1 -> overflow
        exec(16'h0000, 1, 16'h8000, 0, 1, 0);   // undefined opcode
        exec(16'hD800, 1, 16'h8000, 0, 1, 0);   // undefined op under 110

        // Reset in the ALU cycle of ADD R3,R0,R0 aborts before writeback
        @(posedge clk); #1;
        load = 1'b1; in = 16'hA060;
        @(posedge clk); #1;
        load = 1'b0; s = 1'b1;
        @(posedge clk); #1;
        s = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("midadd_busy", w, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midadd_w", w, 1'b1);
        check("midadd_out", out, 16'h0000);
        check("midadd_nvz", {N, V, Z}, 3'b000);
        $display("mid-ADD reset out %h w %b NVZ %b%b%b", out, w, N, V, Z);
        exec(16'hC0E3, 4, 16'h0000, 0, 0, 0);   // MOV R7,R3 -> cleared
        exec(16'hD37F, 2, 16'h0000, 0, 0, 0);   // MOV R3,#127
        exec(16'hC0E3, 4, 16'h007F, 0, 0, 0);   // MOV R7,R3

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
